cmd_frame_decode: RTL
=====================

Name: cmd_frame_decode

Overview:
Parametrised UART command-frame decoder for the SDRAM test path. It is the next generation of the fixed 0x55/0xAA decoder.
- Accepts a frame of one command byte, then ADDR_BYTES address bytes, then (writes only) WR_LEN payload bytes.
- Streams payload bytes into the write FIFO and latches the frame address.
- Pulses wr_trig or rd_trig to the SDRAM arbiter.
- Flags unknown commands and, optionally, stalled frames.

Parameters:
- CMD_WRITE, 8'h55, opcode that starts a write frame.
- CMD_READ, 8'hAA, opcode that starts a read frame.
- ADDR_BYTES, 2, number of address bytes per frame (0..4), big-endian.
- WR_LEN, 4, payload bytes per write frame (1..256).
- TIMEOUT_CYC, 50000, inter-byte timeout in sclk cycles (used only with the macro; must be ≥ 2).

Ports:
- sclk  in  1  system clock
- srst_n  in  1  asynchronous active-low reset
- uart_flag  in  1  one-cycle strobe: uart_data valid
- uart_data  in  8  received byte
- wfifo_wr_en  out  1  write-FIFO push strobe
- wfifo_wdata  out  8  byte to push
- wr_trig  out  1  write frame complete, one-cycle pulse
- rd_trig  out  1  read frame complete, one-cycle pulse
- cmd_addr  out  max(1,8*ADDR_BYTES)  address of the last completed frame
- cmd_err  out  1  unknown opcode, one-cycle pulse
- tmo_err  out  1  frame timeout, one-cycle pulse
- busy  out  1  high while not in S_IDLE

Behaviour:
- Clock and reset: single clock sclk; reset is asynchronous and active-low on srst_n.
- Reset values: every output 0, state S_IDLE, all counters and shift registers 0.
- Output timing: all outputs are registered; each strobe appears exactly 1 cycle after the accepting uart_flag cycle.
- States: S_IDLE, S_ADDR, S_WDATA. A 1-bit op register records write or read.
- S_IDLE:
  - uart_flag with CMD_WRITE → S_ADDR, or S_WDATA if ADDR_BYTES==0.
  - uart_flag with CMD_READ → S_ADDR; if ADDR_BYTES==0, rd_trig pulses and the state stays S_IDLE.
  - Any other byte → cmd_err pulse, stay in S_IDLE.
- S_ADDR:
  - Each flag shifts the byte into the address shift register (MSB first) and increments byte_cnt.
  - On byte ADDR_BYTES-1: byte_cnt clears; cmd_addr loads the full address.
  - Write → S_WDATA. Read → rd_trig pulse and S_IDLE.
- S_WDATA:
  - Each flag gives wfifo_wr_en=1 with wfifo_wdata equal to the byte.
  - Opcode values are treated as plain data in this state.
  - On byte WR_LEN-1: wr_trig pulses in the same cycle as the final wfifo_wr_en; → S_IDLE; byte_cnt clears.
- Address stability: cmd_addr updates only when an address completes and is stable while wr_trig or rd_trig is high.
- Throughput: back-to-back uart_flag every cycle is supported with no lost bytes.
- A new frame may start on the cycle immediately after a trigger.
- Counter: byte_cnt is $clog2(max(WR_LEN,ADDR_BYTES,2)) bits and never wraps past its terminal value.
- Reset mid-frame: outputs clear immediately; partial payload already pushed to the FIFO is not retracted (the FIFO owner flushes on reset).

Optional Feature:
Macro CMD_FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every uart_flag and on entry to S_IDLE, and increments while busy.
  - When it reaches TIMEOUT_CYC-1: tmo_err pulses, state → S_IDLE, byte_cnt clears, wr_trig and rd_trig are suppressed.
  - If uart_flag coincides with expiry, the byte is accepted and the counter clears (no timeout).
- Undefined: no counter is built; tmo_err is tied to 0.

Decomposition:
- Package cmd_frame_pkg holds:
  - state encodings S_IDLE, S_ADDR, S_WDATA;
  - default opcode constants CMD_WRITE_DEF, CMD_READ_DEF;
  - OP_WRITE and OP_READ.
- One sub-module, cmd_frame_timer: timeout counter with clear, enable, and expire pulse. It is instantiated only under the macro.

Test Plan:
1. Defaults, bytes 55 12 34 A1 B2 C3 D4 → wfifo_wr_en ×4 with data A1,B2,C3,D4; wr_trig with the D4 push; cmd_addr=16'h1234.
2. Bytes AA 00 10 → rd_trig 1 cycle after the 0x10 flag; cmd_addr=16'h0010; no wfifo_wr_en.
3. Byte 7E in S_IDLE → cmd_err pulse; no trigger. Then write frame 55 00 01 55 AA 55 AA → 4 pushes of 55,AA,55,AA and wr_trig.
4. Write frame and a read frame with uart_flag every cycle, no gaps → all 4 pushes, wr_trig, then rd_trig; no drops.
5. With the macro and TIMEOUT_CYC=16: send 55 12, then silence → tmo_err at cycle 16 after the last flag; busy=0. Next a full read frame → rd_trig.
6. Assert srst_n=0 after 55 12 34 A1 → all outputs 0 and busy=0. After release, frame AA 00 02 → rd_trig, cmd_addr=16'h0002.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package cmd_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2
    } state_e;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h55;
    localparam logic [7:0] CMD_READ_DEF  = 8'hAA;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cmd_frame_timer.sv
// Inter-byte idle counter; o_expire is high while the count sits at TIMEOUT_CYC-1.
module cmd_frame_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_cnt == CNT_LAST);

endmodule

// File: rtl/cmd_frame_decode.sv
// UART command-frame decoder: opcode, big-endian address, write payload into the FIFO.
// Define CMD_FRAME_TIMEOUT_EN to abandon frames that stall for TIMEOUT_CYC cycles.
module cmd_frame_decode
    import cmd_frame_pkg::*;
#(
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF,
    parameter int         ADDR_BYTES  = 2,
    parameter int         WR_LEN      = 4,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                                            sclk,
    input  logic                                            srst_n,
    input  logic                                            uart_flag,
    input  logic [7:0]                                      uart_data,
    output logic                                            wfifo_wr_en,
    output logic [7:0]                                      wfifo_wdata,
    output logic                                            wr_trig,
    output logic                                            rd_trig,
    output logic [((ADDR_BYTES == 0) ? 1 : 8*ADDR_BYTES)-1:0] cmd_addr,
    output logic                                            cmd_err,
    output logic                                            tmo_err,
    output logic                                            busy
);

    localparam int AW = (ADDR_BYTES == 0) ? 1 : 8*ADDR_BYTES;
    localparam int CW = $clog2(max3(WR_LEN, ADDR_BYTES, 2));
    localparam logic [CW-1:0] ADDR_LAST = CW'((ADDR_BYTES > 0) ? ADDR_BYTES - 1 : 0);
    localparam logic [CW-1:0] WR_LAST   = CW'(WR_LEN - 1);

    if (ADDR_BYTES < 0 || ADDR_BYTES > 4 || WR_LEN < 1 || WR_LEN > 256 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("cmd_frame_decode: parameter out of range");
    end

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_byte_cnt;
    logic [AW-1:0]   r_addr_sh;
    logic [AW-1:0]   r_cmd_addr;
    logic            r_op;
    logic            r_wfifo_wr_en;
    logic [7:0]      r_wfifo_wdata;
    logic            r_wr_trig;
    logic            r_rd_trig;
    logic            r_cmd_err;
    logic            r_tmo_err;
    logic            r_busy;

    logic            w_is_wr;
    logic            w_is_rd;
    logic            w_addr_last;
    logic            w_data_last;
    logic [AW+7:0]   w_addr_ext;
    logic [AW-1:0]   w_addr_shift;
    logic            w_tmo;
    logic            w_push;
    logic            w_wr_trig;
    logic            w_rd_trig;
    logic            w_cmd_err;

    assign w_is_wr      = (uart_data == CMD_WRITE);
    assign w_is_rd      = (uart_data == CMD_READ) && !w_is_wr;
    assign w_addr_last  = (r_byte_cnt == ADDR_LAST);
    assign w_data_last  = (r_byte_cnt == WR_LAST);
    // Appending the byte and keeping the low AW bits works for every address width, including 8.
    assign w_addr_ext   = {r_addr_sh, uart_data};
    assign w_addr_shift = w_addr_ext[AW-1:0];

`ifdef CMD_FRAME_TIMEOUT_EN
    logic w_tmo_raw;

    cmd_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (sclk),
        .i_rst_n  (srst_n),
        .i_clear  (uart_flag | w_tmo_raw | (r_state == S_IDLE)),
        .i_enable (r_state != S_IDLE),
        .o_expire (w_tmo_raw)
    );

    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_tmo = w_tmo_raw && !uart_flag;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo) begin
            w_state_nxt = S_IDLE;
        end else if (uart_flag) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_wr) begin
                        w_state_nxt = (ADDR_BYTES == 0) ? S_WDATA : S_ADDR;
                    end else if (w_is_rd) begin
                        w_state_nxt = (ADDR_BYTES == 0) ? S_IDLE : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_addr_last) begin
                        w_state_nxt = (r_op == OP_WRITE) ? S_WDATA : S_IDLE;
                    end
                end
                S_WDATA: begin
                    if (w_data_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push    = uart_flag && (r_state == S_WDATA) && !w_tmo;
        w_wr_trig = w_push && w_data_last;
        w_rd_trig = 1'b0;
        w_cmd_err = 1'b0;
        if (uart_flag && !w_tmo) begin
            if (r_state == S_IDLE) begin
                w_cmd_err = !w_is_wr && !w_is_rd;
                w_rd_trig = w_is_rd && (ADDR_BYTES == 0);
            end else if (r_state == S_ADDR) begin
                w_rd_trig = w_addr_last && (r_op == OP_READ);
            end
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_byte_cnt <= '0;
            r_addr_sh  <= '0;
            r_cmd_addr <= '0;
            r_op       <= OP_WRITE;
        end else if (w_tmo) begin
            r_byte_cnt <= '0;
        end else if (uart_flag) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_wr) begin
                        r_op <= OP_WRITE;
                    end else if (w_is_rd) begin
                        r_op <= OP_READ;
                    end
                end
                S_ADDR: begin
                    r_addr_sh <= w_addr_shift;
                    if (w_addr_last) begin
                        r_byte_cnt <= '0;
                        r_cmd_addr <= w_addr_shift;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (w_data_last) begin
                        r_byte_cnt <= '0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                    end
                end
                default: r_byte_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_wfifo_wr_en <= 1'b0;
            r_wfifo_wdata <= '0;
            r_wr_trig     <= 1'b0;
            r_rd_trig     <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_tmo_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_wfifo_wr_en <= w_push;
            if (w_push) begin
                r_wfifo_wdata <= uart_data;
            end
            r_wr_trig     <= w_wr_trig;
            r_rd_trig     <= w_rd_trig;
            r_cmd_err     <= w_cmd_err;
            r_tmo_err     <= w_tmo;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    assign wfifo_wr_en = r_wfifo_wr_en;
    assign wfifo_wdata = r_wfifo_wdata;
    assign wr_trig     = r_wr_trig;
    assign rd_trig     = r_rd_trig;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_err     = r_cmd_err;
    assign tmo_err     = r_tmo_err;
    assign busy        = r_busy;

endmodule
